// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program-memory read port plus the decoder-facing IR handshake.
// The master side is the fetch unit; the slave side is memory and decoder.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 12
);
    logic                pmem_req;
    logic [PC_WIDTH-1:0] pmem_addr;
    logic [15:0]         pmem_rdata;
    logic                pmem_rvalid;

    logic [15:0]         instruction;
    logic [7:0]          OP_dk;
    logic [3:0]          OP_s;
    logic                instr_valid;
    logic                instr_ready;
    logic [1:0]          pcInMux_ctrl;
    logic [PC_WIDTH-1:0] pc_target;
    logic [PC_WIDTH-1:0] accum_lo;
    logic [PC_WIDTH-1:0] pc_out;
    logic                fetch_err;

    modport master (
        output pmem_req, pmem_addr, instruction, OP_dk, OP_s,
               instr_valid, pc_out, fetch_err,
        input  pmem_rdata, pmem_rvalid, instr_ready, pcInMux_ctrl,
               pc_target, accum_lo
    );

    modport slave (
        input  pmem_req, pmem_addr, instruction, OP_dk, OP_s,
               instr_valid, pc_out, fetch_err,
        output pmem_rdata, pmem_rvalid, instr_ready, pcInMux_ctrl,
               pc_target, accum_lo
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-word program-memory reads with timeout/retry,
// and an instruction register handed to the decoder with valid/ready.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_FETCH | read strobe issued at PC
//   S_WAIT  | waiting for pmem_rvalid; timeout counter running
//   S_VALID | IR holds an instruction offered to the decoder
module fetch_unit #(
    parameter int                    PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int unsigned           TIMEOUT      = 15
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_WAIT  = 2'b01,
        S_VALID = 2'b10
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic [CNT_W-1:0]    wait_cnt;
    logic                fetch_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_VECTOR;
            ir          <= '0;
            wait_cnt    <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= 1'b0;
            case (state)
                S_FETCH: begin
                    // Down-counter: reaching zero marks the last permitted wait cycle.
                    wait_cnt <= CNT_W'(TIMEOUT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.pmem_rvalid) begin
                        ir    <= bus.pmem_rdata;
                        state <= S_VALID;
                    end else if (wait_cnt == '0) begin
                        fetch_err_q <= 1'b1;
                        state       <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_VALID: begin
                    if (bus.instr_ready) begin
                        case (bus.pcInMux_ctrl)
                            2'b11: begin
                                pc    <= pc + 1'b1;
                                state <= S_FETCH;
                            end
                            2'b01: begin
                                pc    <= bus.pc_target;
                                state <= S_FETCH;
                            end
                            2'b10: begin
                                pc    <= bus.accum_lo;
                                state <= S_FETCH;
                            end
                            default: state <= S_VALID;
                        endcase
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes are decoded from the state register and masked while reset is held.
    assign bus.pmem_req    = (state == S_FETCH) && !reset;
    assign bus.instr_valid = (state == S_VALID) && !reset;
    assign bus.fetch_err   = fetch_err_q && !reset;

    assign bus.pmem_addr   = pc;
    assign bus.pc_out      = pc;
    assign bus.instruction = ir;
    assign bus.OP_dk       = ir[15:8];
    assign bus.OP_s        = ir[15:12];
endmodule
